// File: rtl/bcd_timer_pkg.sv
// Shared constants for the BCD down-timer: presets, digit limit, 7-seg patterns.
// Segment patterns are active-low, bit 0 = segment a ... bit 6 = segment g.
package bcd_timer_pkg;

  localparam logic [3:0] PRESET_TENS_DEF  = 4'd2;
  localparam logic [3:0] PRESET_UNITS_DEF = 4'd4;
  localparam logic [3:0] BCD_MAX          = 4'd9;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic bcd_ok(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_down_timer_if.sv
// Board-side switch and display bundle for the BCD down-timer.
// master = board/bench side, slave = timer side.
interface bcd_down_timer_if;
  logic [15:0] SW;
  logic [7:0]  LEDR;
  logic [0:0]  LEDG;
  logic [6:0]  HEX1;
  logic [6:0]  HEX0;

  modport master (
    output SW,
    input  LEDR, LEDG, HEX1, HEX0
  );

  modport slave (
    input  SW,
    output LEDR, LEDG, HEX1, HEX0
  );
endinterface

// File: rtl/bcd_to_7seg.sv
// BCD digit to active-low seven-segment decoder.
// Non-BCD codes blank the display.
module bcd_to_7seg
  import bcd_timer_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_down_timer.sv
// Two-digit BCD down-counter from a preset, with load/clamp and auto-reload.
// Define BCD_DOWN_TIMER_HEX_EN to drive HEX1/HEX0; otherwise they stay blank.
module bcd_down_timer
  import bcd_timer_pkg::*;
#(
  parameter logic [3:0] PRESET_TENS  = PRESET_TENS_DEF,
  parameter logic [3:0] PRESET_UNITS = PRESET_UNITS_DEF
) (
  input  logic [3:0]           KEY,
  bcd_down_timer_if.slave      io
);

  logic       clk;
  logic       rst;
  logic       load;
  logic       en;
  logic       mode;
  logic [7:0] sw_val;
  logic [7:0] preset;
  logic [7:0] cnt;
  logic [7:0] nxt;
  logic       sw_ok;
  logic       unused_sw;

  assign clk    = KEY[3];
  assign rst    = io.SW[12];
  assign load   = io.SW[13];
  assign en     = io.SW[14];
  assign mode   = io.SW[15];
  assign sw_val = io.SW[7:0];
  assign preset = {PRESET_TENS, PRESET_UNITS};
  assign sw_ok  = bcd_ok(sw_val[7:4]) && bcd_ok(sw_val[3:0]);

  assign unused_sw = ^{KEY[2:0], io.SW[11:8]};

  // Valid BCD orders like binary, so a plain compare does the clamp.
  always_comb begin
    nxt = cnt;
    if (load) begin
      if (sw_ok)
        nxt = (sw_val > preset) ? preset : sw_val;
    end else if (en) begin
      unique case (1'b1)
        cnt[3:0] != 4'd0:
          nxt = {cnt[7:4], cnt[3:0] - 4'd1};
        cnt[3:0] == 4'd0 && cnt[7:4] != 4'd0:
          nxt = {cnt[7:4] - 4'd1, BCD_MAX};
        cnt == 8'h00 && mode:
          nxt = preset;
        default:
          nxt = cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= preset;
    else
      cnt <= nxt;
  end

  assign io.LEDR    = cnt;
  assign io.LEDG[0] = (cnt == 8'h00);

`ifdef BCD_DOWN_TIMER_HEX_EN
  bcd_to_7seg u_hex1 (
    .digit (cnt[7:4]),
    .seg   (io.HEX1)
  );

  bcd_to_7seg u_hex0 (
    .digit (cnt[3:0]),
    .seg   (io.HEX0)
  );
`else
  assign io.HEX1 = SEG_BLANK;
  assign io.HEX0 = SEG_BLANK;
`endif

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed bench for bcd_down_timer with a scoreboard of expected counts.
// Honours BCD_DOWN_TIMER_HEX_EN for the expected HEX values.
module tb_bcd_down_timer;

  logic clk = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] exp_q[$];

  bcd_down_timer_if io ();

  bcd_down_timer #(
    .PRESET_TENS  (4'd2),
    .PRESET_UNITS (4'd4)
  ) dut (
    .KEY ({clk, 3'b000}),
    .io  (io)
  );

  always #5 clk = ~clk;

`ifdef BCD_DOWN_TIMER_HEX_EN
  logic [6:0] segtab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
`endif

  function automatic logic [6:0] hex_exp(input logic [3:0] d);
`ifdef BCD_DOWN_TIMER_HEX_EN
    return segtab[d];
`else
    return (d == 4'hF) ? 7'h7F : 7'h7F;
`endif
  endfunction

  function automatic logic [7:0] bcd(input int n);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(n / 10);
    u = 4'(n % 10);
    return {t, u};
  endfunction

  task automatic check(input string tag);
    logic [7:0] e;
    n_cmp++;
    assert (exp_q.size() != 0) else begin
      n_bad++;
      $error("FAIL %s: scoreboard empty, got %h", tag, io.LEDR);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      assert (io.LEDR === e) else begin
        n_bad++;
        $error("FAIL %s LEDR got %h want %h", tag, io.LEDR, e);
      end
      n_cmp++;
      assert (io.LEDG[0] === (e == 8'h00)) else begin
        n_bad++;
        $error("FAIL %s LEDG got %b want %b", tag, io.LEDG[0], e == 8'h00);
      end
      n_cmp++;
      assert (io.HEX1 === hex_exp(e[7:4])) else begin
        n_bad++;
        $error("FAIL %s HEX1 got %h want %h", tag, io.HEX1, hex_exp(e[7:4]));
      end
      n_cmp++;
      assert (io.HEX0 === hex_exp(e[3:0])) else begin
        n_bad++;
        $error("FAIL %s HEX0 got %h want %h", tag, io.HEX0, hex_exp(e[3:0]));
      end
    end
  endtask

  task automatic step(input logic rst, input logic ld, input logic en,
                      input logic md, input logic [7:0] val,
                      input logic [7:0] e, input string tag);
    @(negedge clk);
    io.SW = {md, en, ld, rst, 4'h0, val};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    io.SW = 16'h0000;
    repeat (2) @(posedge clk);

    step(1, 0, 0, 0, 8'h00, 8'h24, "reset");

    for (int n = 23; n >= 0; n--)
      step(0, 0, 1, 0, 8'h00, bcd(n), $sformatf("down%0d", n));
    step(0, 0, 1, 0, 8'h00, 8'h00, "stop0a");
    step(0, 0, 1, 0, 8'h00, 8'h00, "stop0b");

    step(0, 1, 0, 0, 8'h17, 8'h17, "load17");
    step(0, 1, 0, 0, 8'h3A, 8'h17, "load3A_ign");
    step(0, 1, 0, 0, 8'h31, 8'h24, "load31_clamp");
    step(0, 0, 0, 0, 8'h00, 8'h24, "hold_en0");
    step(0, 1, 0, 0, 8'h10, 8'h10, "load10");
    step(0, 1, 0, 0, 8'h0F, 8'h10, "load0F_ign");
    step(0, 1, 0, 0, 8'h25, 8'h24, "load25_clamp");
    step(0, 1, 0, 0, 8'h24, 8'h24, "load24_edge");

    step(0, 1, 0, 1, 8'h01, 8'h01, "load01");
    step(0, 0, 1, 1, 8'h00, 8'h00, "reload_00");
    step(0, 0, 1, 1, 8'h00, 8'h24, "reload_24");
    step(0, 0, 1, 1, 8'h00, 8'h23, "reload_23");

    step(0, 1, 0, 0, 8'h12, 8'h12, "load12");
    step(1, 1, 0, 0, 8'h05, 8'h24, "rst_over_load");
    step(0, 1, 0, 0, 8'h15, 8'h15, "load15");
    step(0, 1, 1, 0, 8'h09, 8'h09, "load_over_en");
    step(0, 0, 1, 0, 8'h00, 8'h08, "dec09");
    step(0, 1, 0, 0, 8'h20, 8'h20, "load20");
    step(0, 0, 1, 0, 8'h00, 8'h19, "borrow20");
    step(1, 0, 1, 0, 8'h00, 8'h24, "rst_midcount");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
